cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
- Sequences and shares the single unified main-memory port between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between both caches and the multicycle pipelined memory.
- Issues one 8-word block fill per granted miss and returns words to the requesting cache as they arrive.
- Enforces D-side priority, with alternation so the I-side is not starved.

Parameters:
- MEM_LAT, 4: cycles from a read-issue cycle to the cycle mem_data_valid is high with that word.
- WORDS_PER_BLOCK, 8: 16-bit words per cache block (16-byte blocks).
- ADDR_W, 16: byte-address width.
- DATA_W, 16: word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- imiss_req  in  1  I-cache miss pending; held high until imiss_done.
- imiss_addr  in  ADDR_W  I-cache miss byte address.
- imiss_we  out  1  fill-word strobe to I-cache.
- imiss_done  out  1  last-word pulse to I-cache.
- dmiss_req  in  1  D-cache miss pending; held high until dmiss_done.
- dmiss_addr  in  ADDR_W  D-cache miss byte address.
- dmiss_we  out  1  fill-word strobe to D-cache.
- dmiss_done  out  1  last-word pulse to D-cache.
- st_req  in  1  write-through store pending; held high until st_ack.
- st_addr  in  ADDR_W  store address.
- st_data  in  DATA_W  store data.
- st_ack  out  1  store issued this cycle.
- fill_idx  out  3  word index within the block for the current fill_data.
- fill_data  out  DATA_W  returned word, shared by both caches.
- mem_en  out  1  memory request.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_valid  in  1  mem_rdata valid.

Behaviour:
- Reset (rst == 0 at a posedge):
  - State to IDLE; issue and receive counters to 0; last_grant to I.
  - Every output is 0 from the next cycle.
- States: IDLE, FILL, DONE.
- IDLE, one decision per cycle, highest priority first:
  - st_req: drive mem_en = 1, mem_wr = 1, mem_addr = st_addr, mem_wdata = st_data, and st_ack = 1 in the same cycle. Stay in IDLE.
  - Otherwise, both misses pending: grant the side not in last_grant.
  - Otherwise, a single miss pending: grant that side.
  - On a grant: latch base = {addr[15:4], 4'b0} and the owner, then go to FILL.
- FILL:
  - Issue phase: for 8 consecutive cycles, mem_en = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt, with issue_cnt = 0..7. No bubbles.
  - Receive phase: each cycle mem_data_valid is high, pulse the owner's *_we, set fill_idx = rcv_cnt and fill_data = mem_rdata, then increment rcv_cnt.
  - On the 8th word, the owner's *_done is high in the same cycle as its *_we. Go to DONE.
- DONE: one cycle, no outputs. Update last_grant to the owner. Go to IDLE.
  - This cycle lets the requester drop its req, so the same miss is never granted twice.
- Timing: grant decided at cycle 0.
  - Reads issue at cycles 1..8.
  - Word i arrives at cycle 1+i+MEM_LAT, i.e. cycles 5..12.
  - done at cycle 12. IDLE at cycle 14.
- Stores never interleave a fill: st_req raised during FILL or DONE waits and is acked in the first IDLE cycle.
- mem_data_valid is ignored in IDLE and DONE. This covers stale responses still in flight after a reset mid-fill.
- Reset mid-fill: aborts immediately. No done pulse. The requester re-issues its miss normally.
- Addresses: a carry out of bit 3 is impossible by construction; bits [15:4] are never modified.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, FILL, DONE);
  - owner encoding (OWN_I, OWN_D);
  - BLOCK_OFF_BITS = 4;
  - the WORDS_PER_BLOCK default.
- Sub-module fill_counter: 3-bit issue/receive counter with terminal flag, instantiated twice.

Test Plan:
- Lone imiss_req, addr 0x1234 at cycle 0:
  - reads 0x1230, 0x1232 … 0x123E at cycles 1–8;
  - imiss_we at cycles 5–12 with fill_idx 0–7 and data echoed;
  - imiss_done only at cycle 12; dmiss_* stays 0.
- imiss_req and dmiss_req both high at cycle 0 after reset (last_grant = I):
  - D block serviced first;
  - I fill begins with its grant in the first IDLE cycle after D's DONE.
- Repeated dmiss with imiss held: grants alternate D, I, D; the I fill completes within 2 fill periods.
- st_req 0x0040/0xBEEF in IDLE: mem_en = 1, mem_wr = 1, addr 0x0040, wdata 0xBEEF, st_ack in the same cycle.
- st_req raised at cycle 3 of a fill: held without ack until IDLE; then exactly one write and a one-cycle st_ack.
- rst low at cycle 6 of an I fill:
  - all outputs are 0 next cycle;
  - late mem_data_valid pulses produce no *_we;
  - a subsequent dmiss at 0x2000 fills 0x2000–0x200E correctly.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter: state and owner
// encodings, block geometry and memory request payload.
package cache_fill_arbiter_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned MEM_LAT         = 4;
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned BLOCK_OFF_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Clear the byte offset within a block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << BLOCK_OFF_BITS) - 1);
  endfunction

  // Byte address of word idx in a block; base has a zero offset so no carry
  // ever reaches the block-number bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side and memory-side signals of the fill arbiter.
// master: the arbiter; slave: the caches and main memory around it.
interface cache_fill_arbiter_if;
  import cache_fill_arbiter_pkg::*;

  logic              imiss_req;
  logic [ADDR_W-1:0] imiss_addr;
  logic              imiss_we;
  logic              imiss_done;

  logic              dmiss_req;
  logic [ADDR_W-1:0] dmiss_addr;
  logic              dmiss_we;
  logic              dmiss_done;

  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ack;

  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;

  modport master (
    input  imiss_req, imiss_addr, dmiss_req, dmiss_addr,
    input  st_req, st_addr, st_data,
    input  mem_rdata, mem_data_valid,
    output imiss_we, imiss_done, dmiss_we, dmiss_done, st_ack,
    output fill_idx, fill_data,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output imiss_req, imiss_addr, dmiss_req, dmiss_addr,
    output st_req, st_addr, st_data,
    output mem_rdata, mem_data_valid,
    input  imiss_we, imiss_done, dmiss_we, dmiss_done, st_ack,
    input  fill_idx, fill_data,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Word counter within a block fill; term flags the last word index.
module cache_fill_arbiter_fill_counter
  import cache_fill_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] cnt,
  output logic             term
);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  // Clear on a new grant, otherwise step once per word; wraps after the last.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == IDX_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the single main-memory port between I-miss fills, D-miss fills and
// write-through stores. Stores win in IDLE, D wins over I except that
// simultaneous misses alternate against the previous grant. Each grant
// streams one block of reads and forwards the returning words.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cache_fill_arbiter_if.master bus
);

  state_e            state_q;
  state_e            state_d;
  owner_e            owner_q;
  owner_e            owner_d;
  owner_e            last_grant_q;
  owner_e            last_grant_d;
  owner_e            gnt_side;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] base_d;
  logic              issuing_q;
  logic              issuing_d;

  logic              iss_clr;
  logic              iss_inc;
  logic [IDX_W-1:0]  iss_cnt;
  logic              iss_term;
  logic              rcv_clr;
  logic              rcv_inc;
  logic [IDX_W-1:0]  rcv_cnt;
  logic              rcv_term;

  mem_req_t          mem_req_c;
  logic              st_ack_c;
  logic              imiss_we_c;
  logic              imiss_done_c;
  logic              dmiss_we_c;
  logic              dmiss_done_c;
  logic [IDX_W-1:0]  fill_idx_c;
  logic [DATA_W-1:0] fill_data_c;

  cache_fill_arbiter_fill_counter u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (iss_clr),
    .inc  (iss_inc),
    .cnt  (iss_cnt),
    .term (iss_term)
  );

  cache_fill_arbiter_fill_counter u_rcv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (rcv_clr),
    .inc  (rcv_inc),
    .cnt  (rcv_cnt),
    .term (rcv_term)
  );

  // Next-state and port decode: store/grant choice in IDLE, issue and
  // receive streams overlap in FILL, DONE records the owner for alternation.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    issuing_d    = issuing_q;
    gnt_side     = OWN_I;
    iss_clr      = 1'b0;
    iss_inc      = 1'b0;
    rcv_clr      = 1'b0;
    rcv_inc      = 1'b0;
    mem_req_c    = '0;
    st_ack_c     = 1'b0;
    imiss_we_c   = 1'b0;
    imiss_done_c = 1'b0;
    dmiss_we_c   = 1'b0;
    dmiss_done_c = 1'b0;
    fill_idx_c   = '0;
    fill_data_c  = '0;

    case (state_q)
      IDLE: begin
        if (bus.st_req) begin
          mem_req_c.en    = 1'b1;
          mem_req_c.wr    = 1'b1;
          mem_req_c.addr  = bus.st_addr;
          mem_req_c.wdata = bus.st_data;
          st_ack_c        = 1'b1;
        end else if (bus.imiss_req || bus.dmiss_req) begin
          if (bus.imiss_req && bus.dmiss_req) begin
            gnt_side = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
          end else if (bus.dmiss_req) begin
            gnt_side = OWN_D;
          end else begin
            gnt_side = OWN_I;
          end
          owner_d   = gnt_side;
          base_d    = block_base((gnt_side == OWN_D) ? bus.dmiss_addr : bus.imiss_addr);
          issuing_d = 1'b1;
          iss_clr   = 1'b1;
          rcv_clr   = 1'b1;
          state_d   = FILL;
        end
      end

      FILL: begin
        if (issuing_q) begin
          mem_req_c.en   = 1'b1;
          mem_req_c.addr = word_addr(base_q, iss_cnt);
          iss_inc        = 1'b1;
          if (iss_term) begin
            issuing_d = 1'b0;
          end
        end
        if (bus.mem_data_valid) begin
          fill_idx_c  = rcv_cnt;
          fill_data_c = bus.mem_rdata;
          rcv_inc     = 1'b1;
          if (owner_q == OWN_D) begin
            dmiss_we_c   = 1'b1;
            dmiss_done_c = rcv_term;
          end else begin
            imiss_we_c   = 1'b1;
            imiss_done_c = rcv_term;
          end
          if (rcv_term) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and grant bookkeeping with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      base_q       <= '0;
      issuing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      issuing_q    <= issuing_d;
    end
  end

  assign bus.mem_en     = mem_req_c.en;
  assign bus.mem_wr     = mem_req_c.wr;
  assign bus.mem_addr   = mem_req_c.addr;
  assign bus.mem_wdata  = mem_req_c.wdata;
  assign bus.st_ack     = st_ack_c;
  assign bus.imiss_we   = imiss_we_c;
  assign bus.imiss_done = imiss_done_c;
  assign bus.dmiss_we   = dmiss_we_c;
  assign bus.dmiss_done = dmiss_done_c;
  assign bus.fill_idx   = fill_idx_c;
  assign bus.fill_data  = fill_data_c;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: stimulus pushes expected memory
// accesses, fill words and quiet cycles; a negedge monitor pops and compares.
module tb_cache_fill_arbiter;
  import cache_fill_arbiter_pkg::*;

  localparam int END_CYC = 200;

  typedef struct {
    int                cyc;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int                cyc;
    logic              dside;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              done;
  } fill_exp_t;

  logic clk;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];
  int        quiet_q[$];
  mem_exp_t  me;
  fill_exp_t fe;
  logic      side_ok;

  cache_fill_arbiter_if bus();

  cache_fill_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is a fixed scramble of the address, MEM_LAT later.
  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ 16'hC3A5;
  endfunction

  logic [MEM_LAT-1:0] pv = '0;
  logic [ADDR_W-1:0]  pa [MEM_LAT];

  always @(posedge clk) begin
    pv    <= {pv[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
    pa[0] <= bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
  end

  assign bus.mem_data_valid = pv[MEM_LAT-1];
  assign bus.mem_rdata      = pv[MEM_LAT-1] ? rd_word(pa[MEM_LAT-1]) : '0;

  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Grant at cycle g: reads at g+1.., words at g+1+MEM_LAT..
  task automatic exp_fill(input int g, input logic dside, input logic [ADDR_W-1:0] base,
                          input int n_iss, input int n_rcv);
    mem_exp_t  m;
    fill_exp_t f;
    for (int i = 0; i < n_iss; i++) begin
      m.cyc   = g + 1 + i;
      m.wr    = 1'b0;
      m.addr  = base + ADDR_W'(2 * i);
      m.wdata = '0;
      mem_q.push_back(m);
    end
    for (int i = 0; i < n_rcv; i++) begin
      f.cyc   = g + 1 + i + MEM_LAT;
      f.dside = dside;
      f.idx   = IDX_W'(i);
      f.data  = rd_word(base + ADDR_W'(2 * i));
      f.done  = (i == 7);
      fill_q.push_back(f);
    end
  endtask

  task automatic exp_store(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_exp_t m;
    m.cyc   = c;
    m.wr    = 1'b1;
    m.addr  = a;
    m.wdata = d;
    mem_q.push_back(m);
  endtask

  // Stimulus
  initial begin
    bus.imiss_req  = 1'b0;
    bus.imiss_addr = '0;
    bus.dmiss_req  = 1'b0;
    bus.dmiss_addr = '0;
    bus.st_req     = 1'b0;
    bus.st_addr    = '0;
    bus.st_data    = '0;
    quiet_q.push_back(2);
    goto_cyc(3);
    rst = 1'b1;

    // Lone I miss
    goto_cyc(10);
    bus.imiss_req = 1'b1; bus.imiss_addr = 16'h1234;
    exp_fill(10, 1'b0, 16'h1230, 8, 8);
    goto_cyc(23);
    bus.imiss_req = 1'b0;

    // Store in IDLE
    goto_cyc(30);
    bus.st_req = 1'b1; bus.st_addr = 16'h0040; bus.st_data = 16'hBEEF;
    exp_store(30, 16'h0040, 16'hBEEF);
    goto_cyc(31);
    bus.st_req = 1'b0;

    // Both misses, last grant I: D first, I granted right after D's DONE
    goto_cyc(40);
    bus.imiss_req = 1'b1; bus.imiss_addr = 16'h3456;
    bus.dmiss_req = 1'b1; bus.dmiss_addr = 16'h789A;
    exp_fill(40, 1'b1, 16'h7890, 8, 8);
    exp_fill(54, 1'b0, 16'h3450, 8, 8);
    goto_cyc(53);
    bus.dmiss_req = 1'b0;
    goto_cyc(67);
    bus.imiss_req = 1'b0;

    // Repeated D misses with I held: D, I, D
    goto_cyc(80);
    bus.dmiss_req = 1'b1; bus.dmiss_addr = 16'h4000;
    bus.imiss_req = 1'b1; bus.imiss_addr = 16'h5010;
    exp_fill(80, 1'b1, 16'h4000, 8, 8);
    exp_fill(94, 1'b0, 16'h5010, 8, 8);
    exp_fill(108, 1'b1, 16'h4100, 8, 8);
    goto_cyc(93);
    bus.dmiss_req = 1'b0;
    goto_cyc(94);
    bus.dmiss_req = 1'b1; bus.dmiss_addr = 16'h4106;
    goto_cyc(107);
    bus.imiss_req = 1'b0;
    goto_cyc(121);
    bus.dmiss_req = 1'b0;

    // Store raised mid-fill waits for IDLE
    goto_cyc(130);
    bus.dmiss_req = 1'b1; bus.dmiss_addr = 16'h6024;
    exp_fill(130, 1'b1, 16'h6020, 8, 8);
    exp_store(144, 16'h0102, 16'h1357);
    goto_cyc(133);
    bus.st_req = 1'b1; bus.st_addr = 16'h0102; bus.st_data = 16'h1357;
    goto_cyc(143);
    bus.dmiss_req = 1'b0;
    goto_cyc(145);
    bus.st_req = 1'b0;

    // Reset at cycle 6 of an I fill; stale words 2..5 land in 167..170
    goto_cyc(160);
    bus.imiss_req = 1'b1; bus.imiss_addr = 16'h0A0C;
    exp_fill(160, 1'b0, 16'h0A00, 6, 2);
    for (int c = 167; c <= 170; c++) quiet_q.push_back(c);
    goto_cyc(166);
    rst = 1'b0;
    bus.imiss_req = 1'b0;
    goto_cyc(167);
    rst = 1'b1;

    // Fresh D miss after the stale responses drained
    goto_cyc(175);
    bus.dmiss_req = 1'b1; bus.dmiss_addr = 16'h2000;
    exp_fill(175, 1'b1, 16'h2000, 8, 8);
    goto_cyc(188);
    bus.dmiss_req = 1'b0;
  end

  // Monitor: compares every memory access, fill strobe and quiet cycle.
  always @(negedge clk) begin
    if (bus.mem_en) begin
      n_checks++;
      if (mem_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_unexpected cyc=%0d got wr=%b addr=%h wdata=%h ack=%b, required no access",
                 cyc, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.st_ack);
      end else begin
        me = mem_q.pop_front();
        if (cyc != me.cyc || bus.mem_wr != me.wr || bus.mem_addr != me.addr ||
            bus.st_ack != me.wr || (me.wr && bus.mem_wdata != me.wdata)) begin
          n_err++;
          $display("FAIL mem_access got cyc=%0d wr=%b addr=%h wdata=%h ack=%b, required cyc=%0d wr=%b addr=%h wdata=%h ack=%b",
                   cyc, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.st_ack,
                   me.cyc, me.wr, me.addr, me.wdata, me.wr);
        end
      end
    end else if (bus.st_ack) begin
      n_checks++;
      n_err++;
      $display("FAIL st_ack_stray cyc=%0d got st_ack=1 mem_en=0, required st_ack=0", cyc);
    end

    if (bus.imiss_we || bus.dmiss_we || bus.imiss_done || bus.dmiss_done) begin
      n_checks++;
      if (fill_q.size() == 0) begin
        n_err++;
        $display("FAIL fill_unexpected cyc=%0d got we_i=%b done_i=%b we_d=%b done_d=%b idx=%0d, required none",
                 cyc, bus.imiss_we, bus.imiss_done, bus.dmiss_we, bus.dmiss_done, bus.fill_idx);
      end else begin
        fe = fill_q.pop_front();
        side_ok = fe.dside ?
          (bus.dmiss_we && !bus.imiss_we && !bus.imiss_done && bus.dmiss_done == fe.done) :
          (bus.imiss_we && !bus.dmiss_we && !bus.dmiss_done && bus.imiss_done == fe.done);
        if (cyc != fe.cyc || !side_ok || bus.fill_idx != fe.idx || bus.fill_data != fe.data) begin
          n_err++;
          $display("FAIL fill_word got cyc=%0d we_i=%b done_i=%b we_d=%b done_d=%b idx=%0d data=%h, required cyc=%0d side=%s idx=%0d data=%h done=%b",
                   cyc, bus.imiss_we, bus.imiss_done, bus.dmiss_we, bus.dmiss_done,
                   bus.fill_idx, bus.fill_data, fe.cyc, fe.dside ? "D" : "I",
                   fe.idx, fe.data, fe.done);
        end
      end
    end

    if (quiet_q.size() != 0 && quiet_q[0] == cyc) begin
      void'(quiet_q.pop_front());
      n_checks++;
      if ({bus.mem_en, bus.mem_wr, bus.st_ack, bus.imiss_we, bus.imiss_done,
           bus.dmiss_we, bus.dmiss_done, bus.fill_idx, bus.fill_data,
           bus.mem_addr, bus.mem_wdata} != '0) begin
        n_err++;
        $display("FAIL quiet_outputs cyc=%0d got en=%b wr=%b ack=%b we_i=%b we_d=%b idx=%0d data=%h addr=%h valid=%b, required all zero",
                 cyc, bus.mem_en, bus.mem_wr, bus.st_ack, bus.imiss_we, bus.dmiss_we,
                 bus.fill_idx, bus.fill_data, bus.mem_addr, bus.mem_data_valid);
      end
    end

    if (cyc == END_CYC) begin
      n_checks++;
      if (mem_q.size() != 0 || fill_q.size() != 0 || quiet_q.size() != 0) begin
        n_err++;
        $display("FAIL pending_expectations got mem=%0d fill=%0d quiet=%0d left, required 0 0 0",
                 mem_q.size(), fill_q.size(), quiet_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
    end
  end

endmodule
